// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM device model: command encodings, bank
// states and default timing values.
package dram_pkg;

    typedef enum logic [1:0] {
        CMD_NOP = 2'b00,
        CMD_ACT = 2'b01,
        CMD_COL = 2'b10,
        CMD_PRE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        BANK_IDLE,
        BANK_ACTIVATING,
        BANK_ACTIVE,
        BANK_PRECHARGING
    } bank_state_e;

    localparam int DEF_T_RCD = 2;
    localparam int DEF_T_RP  = 2;
    localparam int DEF_CL    = 3;

endpackage

// File: rtl/dram_bank_fsm.sv
// One DRAM bank: state machine, open-row register and tRCD/tRP timer.
// Flags commands that are illegal for the current state without acting on them.
module dram_bank_fsm
    import dram_pkg::*;
#(
    parameter int ROW_W = 7,
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RP  = DEF_T_RP
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             sel_i,
    input  cmd_e             cmd_i,
    input  logic [ROW_W-1:0] row_i,
    output logic             illegal_o,
    output logic             open_o,
    output logic [ROW_W-1:0] open_row_o
);

    localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam logic [TMR_W-1:0] RCD_LOAD = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    bank_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [ROW_W-1:0] row_q, row_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the combinational block below uses blocking ones.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= BANK_IDLE;
            timer_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            row_q   <= row_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        row_d     = row_q;
        illegal_o = 1'b0;
        unique case (state_q)
            BANK_IDLE: begin
                if (sel_i && cmd_i == CMD_ACT) begin
                    row_d = row_i;
                    if (T_RCD == 1) begin
                        state_d = BANK_ACTIVE;
                    end else begin
                        state_d = BANK_ACTIVATING;
                        timer_d = RCD_LOAD;
                    end
                end else if (sel_i && cmd_i == CMD_COL) begin
                    illegal_o = 1'b1;
                end
            end
            BANK_ACTIVATING: begin
                illegal_o = sel_i && (cmd_i != CMD_NOP);
                // The countdown keeps running even when a command is rejected.
                if (timer_q > TMR_ONE) begin
                    timer_d = timer_q - TMR_ONE;
                end else begin
                    timer_d = '0;
                    state_d = BANK_ACTIVE;
                end
            end
            BANK_ACTIVE: begin
                if (sel_i && cmd_i == CMD_ACT) begin
                    illegal_o = 1'b1;
                end else if (sel_i && cmd_i == CMD_PRE) begin
                    if (T_RP == 1) begin
                        state_d = BANK_IDLE;
                    end else begin
                        state_d = BANK_PRECHARGING;
                        timer_d = RP_LOAD;
                    end
                end
            end
            BANK_PRECHARGING: begin
                illegal_o = sel_i && (cmd_i != CMD_NOP);
                if (timer_q > TMR_ONE) begin
                    timer_d = timer_q - TMR_ONE;
                end else begin
                    timer_d = '0;
                    state_d = BANK_IDLE;
                end
            end
            default: state_d = BANK_IDLE;
        endcase
    end

    assign open_o     = (state_q == BANK_ACTIVE);
    assign open_row_o = row_q;

endmodule

// File: rtl/dram_device_model.sv
// Multi-bank DRAM device model: per-bank FSMs, shared storage array and a
// CL-deep registered read pipeline with a one-cycle illegal-command flag.
module dram_device_model
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH   = 1,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int CL           = DEF_CL,
    localparam int BANK_W      = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1,
    localparam int ROW_W       = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1,
    localparam int COL_W       = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    cs_n,
    input  logic [1:0]              cmd,
    input  logic                    we,
    input  logic [BANK_W-1:0]       bank,
    input  logic [ROW_W-1:0]        row,
    input  logic [COL_W-1:0]        col,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    err,
    output logic [NUM_OF_BANKS-1:0] bank_open
);

    localparam int DEPTH  = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_e                    cmd_w;
    logic [NUM_OF_BANKS-1:0] bank_sel;
    logic [NUM_OF_BANKS-1:0] bank_illegal;
    logic [ROW_W-1:0]        open_row [NUM_OF_BANKS];
    logic                    col_ok;
    logic                    rd_go;
    logic [ADDR_W-1:0]       addr;

    assign cmd_w = cmd_e'(cmd);

    for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_bank
        assign bank_sel[b] = !cs_n && (bank == BANK_W'(b)) && (cmd_w != CMD_NOP);

        dram_bank_fsm #(
            .ROW_W (ROW_W),
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk        (clk),
            .rst_b      (rst_b),
            .sel_i      (bank_sel[b]),
            .cmd_i      (cmd_w),
            .row_i      (row),
            .illegal_o  (bank_illegal[b]),
            .open_o     (bank_open[b]),
            .open_row_o (open_row[b])
        );
    end

    // Column accesses use the bank's latched row; the row input is ignored.
    assign col_ok = !cs_n && (cmd_w == CMD_COL) && bank_open[bank];
    assign rd_go  = col_ok && !we;
    assign addr   = ADDR_W'((int'(bank) * NUM_OF_ROWS + int'(open_row[bank]))
                            * NUM_OF_COLS + int'(col));

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; only control state is cleared,
    // so the array maps onto plain RAM without per-word reset logic.
    always_ff @(posedge clk) begin
        if (col_ok && we) begin
            mem[addr] <= data_in;
        end
    end

    logic                  vld_q [CL];
    logic [DATA_WIDTH-1:0] dat_q [CL];
    logic                  err_q;

    // Data is zeroed alongside valid so data_out stays 0 between reads.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < CL; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            vld_q[0] <= rd_go;
            dat_q[0] <= rd_go ? mem[addr] : '0;
            for (int i = 1; i < CL; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            err_q <= |bank_illegal;
        end
    end

    assign data_valid = vld_q[CL-1];
    assign data_out   = dat_q[CL-1];
    assign err        = err_q;

endmodule

// File: doc/dram_device_model.md
DRAM_DEVICE_MODEL -- requirements
Module: dram_device_model

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, bits per column location.
REQ-002 SHALL have parameter NUM_OF_BANKS, default 8, number of independent banks.
REQ-003 SHALL have parameter NUM_OF_ROWS, default 128, rows per bank.
REQ-004 SHALL have parameter NUM_OF_COLS, default 8, columns per row.
REQ-005 SHALL have parameters T_RCD, default 2; T_RP, default 2; CL, default 3; all cycle counts >=1.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_b input 1, asynchronous active-low reset.
REQ-007 SHALL have cs_n input 1: chip select, active low; cmd ignored when high.
REQ-008 SHALL have cmd input 2: 00 NOP, 01 ACTIVATE, 10 COLUMN (read/write), 11 PRECHARGE.
REQ-009 SHALL have we input 1: on COLUMN, 1 = write, 0 = read.
REQ-010 SHALL have bank input $clog2(NUM_OF_BANKS), row input $clog2(NUM_OF_ROWS), and col input $clog2(NUM_OF_COLS): target address.
REQ-011 SHALL have data_in input DATA_WIDTH: write data, sampled with the COLUMN write command.
REQ-012 SHALL have data_out output DATA_WIDTH and data_valid output 1: read data, with a one-cycle qualifier.
REQ-013 SHALL have err output 1: one-cycle pulse flagging an illegal command.
REQ-014 SHALL have bank_open output NUM_OF_BANKS: bit b high while bank b is ACTIVE.

Function
REQ-015 Each bank SHALL run an FSM: IDLE, ACTIVATING, ACTIVE, PRECHARGING.
REQ-016 ACTIVATE to an IDLE bank at cycle N SHALL latch row and enter ACTIVATING; the bank SHALL become ACTIVE so that a COLUMN command at N+T_RCD is legal.
REQ-017 PRECHARGE to an ACTIVE bank at cycle N SHALL enter PRECHARGING; the bank SHALL become IDLE so that an ACTIVATE at N+T_RP is legal.
REQ-018 PRECHARGE to an IDLE bank SHALL be a legal no-op.
REQ-019 COLUMN write to an ACTIVE bank SHALL store data_in at [bank][open row][col] at the command edge; row input SHALL be ignored.
REQ-020 COLUMN read to an ACTIVE bank at cycle N SHALL drive data_out with data_valid=1 in cycle N+CL only, from the open row.
REQ-021 The read path SHALL be a CL-deep pipeline; one read per cycle SHALL be sustained, and reads to different banks SHALL interleave freely.
REQ-022 A read issued the cycle after a write to the same location SHALL return the new data.
REQ-023 Illegal commands SHALL be ignored with no state or array change, and SHALL assert err for the following cycle. Illegal cases: ACTIVATE to a non-IDLE bank; COLUMN to a non-ACTIVE bank; PRECHARGE to an ACTIVATING or PRECHARGING bank.
REQ-024 Banks SHALL be independent: a command to bank A SHALL never alter bank B state or timers.
REQ-025 Timer counters SHALL saturate at zero; T_RCD=1 and T_RP=1 SHALL mean a legal follow-up on the next cycle.
REQ-026 data_out, data_valid, and err SHALL be registered; data_out SHALL be 0 when data_valid is 0.

Reset
REQ-027 While rst_b=0, all banks SHALL be IDLE, all timers 0, the read pipeline cleared, and data_out, data_valid, err, and bank_open all 0.
REQ-028 Reset mid-operation SHALL drop in-flight reads (no data_valid after release) and close all open rows.
REQ-029 The storage array SHALL NOT be reset; its contents SHALL be undefined until written.

Structure
REQ-030 Shared package dram_pkg SHALL hold the cmd encodings (CMD_NOP, CMD_ACT, CMD_COL, CMD_PRE), the bank-state enum, and the default T_RCD, T_RP, and CL values.
REQ-031 A sub-module dram_bank_fsm SHALL hold the per-bank FSM, open-row register, and timer, generated NUM_OF_BANKS times; the array and read pipeline SHALL live in the top level.

Verification
REQ-032 Bench SHALL run ACT b3 r5 @0; WR b3 c2 data 1 @2; RD b3 c2 @3, and SHALL see data_valid=1 with data_out=1 at cycle 6 only.
REQ-033 Bench SHALL run ACT b1 r9 @0 then RD b1 @1 (before T_RCD), and SHALL see err=1 @2, no data_valid, and the bank still reaching ACTIVE @2.
REQ-034 Bench SHALL run ACT b0 and b7 with back-to-back RDs b0, b7, b0 @4,5,6, and SHALL see data_valid at 7,8,9 with the correct per-bank data.
REQ-035 Bench SHALL run PRE b2 @10 then ACT b2 @11, and SHALL see err @12; a repeated ACT b2 @12 SHALL be accepted and bank_open[2] SHALL rise @14.
REQ-036 Bench SHALL drop rst_b for one cycle between a RD and its CL slot, and SHALL see no data_valid and bank_open=0 after release.
REQ-037 Bench SHALL issue commands with cs_n=1 (ACT, RD), and SHALL see no state change, no err, and no data_valid.
